// File: rtl/overcooked_link_pkg.sv
// Shared constants and state types for the player-controller serial link.
// Used by player_link_rx and uart_rx_byte.
package overcooked_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 7;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_CHOP  = 4;
  localparam int BTN_CARRY = 5;
  localparam int BTN_PAUSE = 6;

  // One parser state per frame byte: HUNT waits for sync, the rest name the byte expected next.
  typedef enum logic [$clog2(FRAME_LEN)-1:0] {
    ST_HUNT, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_CSUM
  } parse_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
// byte_valid / stop_err pulse one cycle after the cycle following the stop sample.
module uart_rx_byte
  import overcooked_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_reg;
  logic          rx_prev_reg;
  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          stop_ok_reg, stop_ok_next;
  logic          stop_bad_reg, stop_bad_next;
  logic          valid_reg, err_reg;
  logic          rx_s;

  assign rx_s = sync_reg[1];

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    stop_ok_next  = 1'b0;
    stop_bad_next = 1'b0;
    unique case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (rx_prev_reg && !rx_s) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          // A start bit that has gone high again was a glitch.
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end else cnt_next = cnt_reg + 1'b1;
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = RX_STOP;
          else bit_next = bit_reg + 1'b1;
        end else cnt_next = cnt_reg + 1'b1;
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          state_next    = RX_IDLE;
          stop_ok_next  = rx_s;
          stop_bad_next = !rx_s;
        end else cnt_next = cnt_reg + 1'b1;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg     <= 2'b11;
      rx_prev_reg  <= 1'b1;
      state_reg    <= RX_IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      stop_ok_reg  <= 1'b0;
      stop_bad_reg <= 1'b0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], rx_in};
      rx_prev_reg  <= rx_s;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      stop_ok_reg  <= stop_ok_next;
      stop_bad_reg <= stop_bad_next;
      valid_reg    <= stop_ok_reg;
      err_reg      <= stop_bad_reg;
    end
  end

  assign byte_out   = shift_reg;
  assign byte_valid = valid_reg;
  assign stop_err   = err_reg;

endmodule

// File: rtl/player_link_rx.sv
// Player-controller packet receiver: parses 7-byte frames and holds per-player registers.
// Define PLAYER_LINK_CHECKSUM_EN to drop frames whose checksum byte does not match.
module player_link_rx
  import overcooked_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic            clk_in,
  input  logic            reset_n,
  input  logic            rx_in,
  output logic [3:0][8:0] player_x,
  output logic [3:0][8:0] player_y,
  output logic [3:0][1:0] player_direction,
  output logic [3:0][3:0] player_state,
  output logic [3:0][6:0] player_buttons,
  output logic            frame_valid,
  output logic [1:0]      frame_player,
  output logic [7:0]      framing_err,
  output logic [7:0]      frame_err
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]   rx_byte;
  logic         rx_valid, rx_stop_err;
  parse_state_t state_reg, state_next;
  logic         commit, drop, timeout;
  logic [TW-1:0] idle_cnt_reg;
  logic [7:0]   b1_reg, x_lo_reg, y_lo_reg, b4_reg;
  logic         pause_reg;
  logic [6:0]   btn_stage;
  logic [1:0]   id;
  logic         frame_valid_reg;
  logic [1:0]   frame_player_reg;
  logic [7:0]   framing_err_reg, frame_err_reg;
`ifdef PLAYER_LINK_CHECKSUM_EN
  logic [7:0]   csum_reg;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .rx_in     (rx_in),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .stop_err  (rx_stop_err)
  );

  // A framing error on the same cycle takes precedence over the timeout.
  assign timeout = (state_reg != ST_HUNT) && !rx_valid && !rx_stop_err &&
                   (idle_cnt_reg >= TW'(TIMEOUT_CLKS));

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    drop       = 1'b0;
    if (rx_stop_err) state_next = ST_HUNT;
    else if (rx_valid) begin
      case (state_reg)
        ST_HUNT: if (rx_byte == SYNC_BYTE) state_next = ST_B1;
        ST_B1:   state_next = ST_B2;
        ST_B2:   state_next = ST_B3;
        ST_B3:   state_next = ST_B4;
        ST_B4:   state_next = ST_B5;
        ST_B5:   state_next = ST_CSUM;
        ST_CSUM: begin
          state_next = ST_HUNT;
`ifdef PLAYER_LINK_CHECKSUM_EN
          if (rx_byte == csum_reg) commit = 1'b1;
          else drop = 1'b1;
`else
          commit = 1'b1;
`endif
        end
        default: state_next = ST_HUNT;
      endcase
    end else if (timeout) state_next = ST_HUNT;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_HUNT;
      idle_cnt_reg <= '0;
      b1_reg       <= '0;
      x_lo_reg     <= '0;
      y_lo_reg     <= '0;
      b4_reg       <= '0;
      pause_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_HUNT || rx_valid) idle_cnt_reg <= '0;
      else if (!(&idle_cnt_reg)) idle_cnt_reg <= idle_cnt_reg + 1'b1;
      if (rx_valid) begin
        case (state_reg)
          ST_B1:   b1_reg    <= rx_byte;
          ST_B2:   x_lo_reg  <= rx_byte;
          ST_B3:   y_lo_reg  <= rx_byte;
          ST_B4:   b4_reg    <= rx_byte;
          ST_B5:   pause_reg <= rx_byte[7];
          default: ;
        endcase
      end
    end
  end

`ifdef PLAYER_LINK_CHECKSUM_EN
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) csum_reg <= '0;
    else if (rx_valid) csum_reg <= (state_reg == ST_HUNT) ? 8'h00 : (csum_reg ^ rx_byte);
  end
`endif

  always_comb begin
    btn_stage            = '0;
    btn_stage[BTN_LEFT]  = b4_reg[0];
    btn_stage[BTN_RIGHT] = b4_reg[1];
    btn_stage[BTN_UP]    = b4_reg[2];
    btn_stage[BTN_DOWN]  = b4_reg[3];
    btn_stage[BTN_CHOP]  = b4_reg[4];
    btn_stage[BTN_CARRY] = b4_reg[5];
    btn_stage[BTN_PAUSE] = pause_reg;
  end

  assign id = b1_reg[7:6];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_player
      logic [8:0] x_reg, y_reg;
      logic [1:0] dir_reg;
      logic [3:0] st_reg;
      logic [6:0] btn_reg;
      always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
          x_reg   <= '0;
          y_reg   <= '0;
          dir_reg <= '0;
          st_reg  <= '0;
          btn_reg <= '0;
        end else if (commit && id == 2'(gi)) begin
          x_reg   <= {b4_reg[7], x_lo_reg};
          y_reg   <= {b4_reg[6], y_lo_reg};
          dir_reg <= b1_reg[5:4];
          st_reg  <= b1_reg[3:0];
          btn_reg <= btn_stage;
        end
      end
      assign player_x[gi]         = x_reg;
      assign player_y[gi]         = y_reg;
      assign player_direction[gi] = dir_reg;
      assign player_state[gi]     = st_reg;
      assign player_buttons[gi]   = btn_reg;
    end
  endgenerate

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid_reg  <= 1'b0;
      frame_player_reg <= '0;
      framing_err_reg  <= '0;
      frame_err_reg    <= '0;
    end else begin
      frame_valid_reg <= commit;
      if (commit) frame_player_reg <= id;
      if (rx_stop_err && framing_err_reg != 8'hFF) framing_err_reg <= framing_err_reg + 1'b1;
      if ((timeout || drop) && frame_err_reg != 8'hFF) frame_err_reg <= frame_err_reg + 1'b1;
    end
  end

  assign frame_valid  = frame_valid_reg;
  assign frame_player = frame_player_reg;
  assign framing_err  = framing_err_reg;
  assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_player_link_rx.sv
// Scoreboard bench for player_link_rx: directed frames push expected commits,
// a monitor pops and compares on every frame_valid pulse.
module tb_player_link_rx;

  localparam int CPB = 16;
  localparam int TMO = 400;

  typedef struct packed {
    logic [1:0] p;
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] d;
    logic [3:0] s;
    logic [6:0] b;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            rx;
  logic [3:0][8:0] player_x, player_y;
  logic [3:0][1:0] player_direction;
  logic [3:0][3:0] player_state;
  logic [3:0][6:0] player_buttons;
  logic            frame_valid;
  logic [1:0]      frame_player;
  logic [7:0]      framing_err, frame_err;

  int   checks = 0;
  int   errors = 0;
  int   commits = 0;
  int   exp_commits = 0;
  int   exp_fe = 0;
  exp_t exp_q[$];
  exp_t model[4];

  always #5 clk = ~clk;

  player_link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk_in          (clk),
    .reset_n         (reset_n),
    .rx_in           (rx),
    .player_x        (player_x),
    .player_y        (player_y),
    .player_direction(player_direction),
    .player_state    (player_state),
    .player_buttons  (player_buttons),
    .frame_valid     (frame_valid),
    .frame_player    (frame_player),
    .framing_err     (framing_err),
    .frame_err       (frame_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [55:0] f);
    for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] p, input logic [8:0] x, input logic [8:0] y,
                      input logic [1:0] d, input logic [3:0] s, input logic [6:0] b);
    exp_t e;
    e.p = p; e.x = x; e.y = y; e.d = d; e.s = s; e.b = b;
    exp_q.push_back(e);
    exp_commits++;
  endtask

  // Monitor: every frame_valid pulse must match the oldest expected commit,
  // and all four players must equal the bench's running picture of them.
  initial begin
    for (int p = 0; p < 4; p++) model[p] = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int p = 0; p < 4; p++) model[p] = '0;
      end else if (frame_valid) begin
        commits++;
        $display("commit %0d: player %0d x=%0h y=%0h dir=%0d state=%0h btn=%0h", commits,
                 frame_player, player_x[frame_player], player_y[frame_player],
                 player_direction[frame_player], player_state[frame_player],
                 player_buttons[frame_player]);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: frame_player=%0d with no commit expected", frame_player);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          model[e.p] = e;
          chk("frame_player", 64'(frame_player), 64'(e.p));
          for (int p = 0; p < 4; p++) begin
            chk($sformatf("p%0d_x", p), 64'(player_x[p]), 64'(model[p].x));
            chk($sformatf("p%0d_y", p), 64'(player_y[p]), 64'(model[p].y));
            chk($sformatf("p%0d_dir", p), 64'(player_direction[p]), 64'(model[p].d));
            chk($sformatf("p%0d_state", p), 64'(player_state[p]), 64'(model[p].s));
            chk($sformatf("p%0d_btn", p), 64'(player_buttons[p]), 64'(model[p].b));
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, 64'(player_x), 64'd0);
    chk({tag, "_y"}, 64'(player_y), 64'd0);
    chk({tag, "_dir"}, 64'(player_direction), 64'd0);
    chk({tag, "_state"}, 64'(player_state), 64'd0);
    chk({tag, "_btn"}, 64'(player_buttons), 64'd0);
  endtask

  initial begin
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_frame_valid", 64'(frame_valid), 64'd0);
    chk("reset_frame_player", 64'(frame_player), 64'd0);
    chk("reset_framing_err", 64'(framing_err), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    reset_n = 1'b1;
    idle(40);

    // Good frame for player 1.
    push(2'd1, 9'h134, 9'h112, 2'd2, 4'd2, 7'h45);
    send_frame(56'hA5_62_34_12_C5_80_01);
    idle(3 * CPB);
    chk("good_frame_err", 64'(frame_err), 64'd0);

    // Same frame with a wrong checksum byte.
`ifdef PLAYER_LINK_CHECKSUM_EN
    exp_fe++;
`else
    push(2'd1, 9'h134, 9'h112, 2'd2, 4'd2, 7'h45);
`endif
    send_frame(56'hA5_62_34_12_C5_80_00);
    idle(3 * CPB);
    chk("badcsum_frame_err", 64'(frame_err), 64'(exp_fe));

    // Bad stop bit on B3, tail ignored in HUNT, then a good frame for player 3.
    send_byte(8'hA5);
    send_byte(8'h62);
    send_byte(8'h34);
    send_byte(8'h12, 1'b0);
    idle(2 * CPB);
    send_byte(8'hC5);
    send_byte(8'h80);
    send_byte(8'h01);
    idle(3 * CPB);
    chk("framing_err_count", 64'(framing_err), 64'd1);
    chk("framing_frame_err", 64'(frame_err), 64'(exp_fe));
    push(2'd3, 9'h00F, 9'h1FF, 2'd1, 4'hA, 7'h2A);
    send_frame(56'hA5_DA_0F_FF_6A_7F_3F);
    idle(3 * CPB);

    // Stall after B1 long enough to time out, then a fresh player-1 frame.
    send_byte(8'hA5);
    send_byte(8'h62);
    idle(TMO + 2 * CPB);
    exp_fe++;
    chk("timeout_frame_err", 64'(frame_err), 64'(exp_fe));
    push(2'd1, 9'h000, 9'h080, 2'd1, 4'd1, 7'h00);
    send_frame(56'hA5_51_00_80_00_00_D1);
    idle(3 * CPB);

    // Garbage while hunting, then back-to-back frames for players 0 and 2.
    send_byte(8'h11);
    send_byte(8'h5A);
    send_byte(8'hFF);
    push(2'd0, 9'h1A5, 9'h000, 2'd3, 4'd5, 7'h51);
    push(2'd2, 9'h0FF, 9'h001, 2'd0, 4'hF, 7'h7F);
    send_frame(56'hA5_35_A5_00_91_80_81);
    send_frame(56'hA5_8F_FF_01_3F_FF_B1);
    idle(3 * CPB);
    chk("hunt_framing_err", 64'(framing_err), 64'd1);
    chk("hunt_frame_err", 64'(frame_err), 64'(exp_fe));
    chk("pending_before_reset", 64'(exp_q.size()), 64'd0);
    chk("commit_count", 64'(commits), 64'(exp_commits));

    // Reset in the middle of B4; the frame tail must not commit.
    send_byte(8'hA5);
    send_byte(8'hDA);
    send_byte(8'h0F);
    send_byte(8'hFF);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_framing_err", 64'(framing_err), 64'd0);
    chk("midreset_frame_err", 64'(frame_err), 64'd0);
    chk("midreset_frame_player", 64'(frame_player), 64'd0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    send_byte(8'h7F);
    send_byte(8'h3F);
    idle(TMO + 4 * CPB);
    chk_all_zero("after_reset_tail");
    chk("final_commit_count", 64'(commits), 64'(exp_commits));
    chk("final_pending", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
